fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 LINE_NUM, default 2, number of icache lines.
REQ-002 WORDS_PER_LINE, default 16, words per line.
REQ-003 WORD_WIDTH, default 32, instruction width.
REQ-004 FETCH_WIDTH, default 4, words per fetch batch.
REQ-005 IQ_DEPTH, default 8, instruction queue depth, power of two, >= FETCH_WIDTH.
REQ-006 RESET_ADDR, default 0, word index fetched first after reset.
REQ-007 Derived: TOTAL = LINE_NUM*WORDS_PER_LINE; ADDR_W = $clog2(TOTAL).
REQ-008 clk  input  1  sole clock, rising edge.
REQ-009 rst_n  input  1  asynchronous, active-low reset.
REQ-010 fetch_addr  output  ADDR_W  word index presented to icache; registered.
REQ-011 inst_batch  input  FETCH_WIDTH x WORD_WIDTH  icache batch, combinationally valid for the current fetch_addr in the same cycle.
REQ-012 redirect_valid  input  1  flush and restart request.
REQ-013 redirect_addr  input  ADDR_W  restart word index.
REQ-014 out_valid  output  1  out_inst/out_pc valid.
REQ-015 out_ready  input  1  decode accepts.
REQ-016 out_inst  output  WORD_WIDTH  head-of-queue instruction.
REQ-017 out_pc  output  ADDR_W  word index of out_inst.
REQ-018 stall_cycles  output  32  perf counter (see Configuration).
REQ-019 fetch_count  output  32  perf counter (see Configuration).

Function
REQ-020 States: RUN, STALL, END; internal pointer ptr is ADDR_W+1 bits; fetch_addr = ptr[ADDR_W-1:0].
REQ-021 RUN and free slots (IQ_DEPTH - count, pre-edge) >= FETCH_WIDTH: enqueue n = min(FETCH_WIDTH, TOTAL - ptr) words inst_batch[0..n-1] with pcs ptr..ptr+n-1 at the edge; ptr += n.
REQ-022 RUN and free < FETCH_WIDTH: no enqueue, next state STALL; STALL returns to RUN when free >= FETCH_WIDTH (enqueue resumes the following cycle).
REQ-023 ptr reaching TOTAL: next state END; no further enqueue; fetch_addr holds its last value.
REQ-024 Same-edge dequeue does not increase free slots for the enqueue decision.
REQ-025 Dequeue when out_valid && out_ready; out_valid = queue not empty; in-order delivery, one word per cycle max.
REQ-026 redirect_valid has priority over all: queue emptied, ptr = redirect_addr, state RUN, no enqueue or dequeue effect that edge; out_valid 0 the next cycle.
REQ-027 Latency: word fetched at edge N is visible on out_inst after edge N if queue was empty.
REQ-028 No enqueue of partial batch except at TOTAL boundary (REQ-021).

Reset
REQ-029 rst_n low: ptr = RESET_ADDR, state RUN, queue empty, out_valid 0, out_inst 0, out_pc 0, counters 0; deassertion mid-run restarts from RESET_ADDR.

Configuration
REQ-030 Macro FETCH_PERF_EN: defined -> stall_cycles increments each cycle in STALL, fetch_count adds n per enqueue; both saturate at 2^32-1; cleared by reset only.
REQ-031 FETCH_PERF_EN undefined -> both ports present and constant 0, no counter flops.

Structure
REQ-032 Package fetch_pkg: state enum (RUN, STALL, END), RV_NOP = 32'h00000013.
REQ-033 Sub-module fetch_iq: circular buffer of {inst, pc}, multi-word push (0..FETCH_WIDTH), single pop, flush, count output.

Verification (icache model mem[i] = 32'h1000+i)
REQ-034 Reset, out_ready=1 -> out_pc 0,1,2,...,31 with out_inst 32'h1000..32'h101F in order, then END, out_valid 0.
REQ-035 out_ready=0 -> after 2 enqueues count=8, state STALL, fetch_addr stays 8; raise out_ready -> RUN resumes when count <= 4.
REQ-036 Redirect to 30 while queue holds 6 -> next cycle out_valid 0; then pcs 30,31 only (partial batch n=2), END.
REQ-037 Redirect asserted same cycle as dequeue and enqueue-eligible -> queue empty, ptr = redirect_addr, no stray word delivered.
REQ-038 rst_n pulsed low mid-run at ptr=12 -> outputs zero immediately, fetch restarts at 0.
REQ-039 With FETCH_PERF_EN, scenario REQ-035 holding out_ready=0 10 cycles in STALL -> stall_cycles=10, fetch_count=8; without macro both read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    END   = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RV_NOP = 32'h00000013;

endpackage

// File: rtl/fetch_iq.sv
// Circular instruction queue of {inst, pc}: pushes 0..FW consecutive words per
// cycle, pops at most one, flush empties it in a single cycle.
module fetch_iq
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int FW    = 4,
  parameter int WW    = 32,
  parameter int AW    = 5,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int NW   = $clog2(FW + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NW-1:0]         push_cnt,
  input  logic [FW-1:0][WW-1:0] push_inst,
  input  logic [AW-1:0]         push_pc,
  input  logic                  pop,
  output logic [WW-1:0]         head_inst,
  output logic [AW-1:0]         head_pc,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WW-1:0]              inst_mem [DEPTH];
  logic [AW-1:0]              pc_mem   [DEPTH];
  logic [PW-1:0]              rd_ptr_reg;
  logic [PW-1:0]              wr_ptr_reg;
  logic [CW-1:0]              count_reg;
  logic [DEPTH-1:0]           slot_we;
  logic [DEPTH-1:0][WW-1:0]   slot_inst;
  logic [DEPTH-1:0][AW-1:0]   slot_pc;
  logic                       pop_ok;

  // Each slot works out which word of the incoming batch (if any) lands in it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [PW-1:0] offset;
    logic [WW-1:0] sel_inst;

    assign offset = PW'(gi) - wr_ptr_reg;

    always_comb begin
      sel_inst = push_inst[0];
      for (int k = 0; k < FW; k++) begin
        if (offset == PW'(k)) sel_inst = push_inst[k];
      end
    end

    assign slot_we[gi]   = 32'(offset) < 32'(push_cnt);
    assign slot_inst[gi] = sel_inst;
    assign slot_pc[gi]   = push_pc + AW'(offset);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        inst_mem[k] <= WW'(RV_NOP);
        pc_mem[k]   <= '0;
      end
    end else if (!flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (slot_we[k]) begin
          inst_mem[k] <= slot_inst[k];
          pc_mem[k]   <= slot_pc[k];
        end
      end
    end
  end

  assign pop_ok = pop && (count_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_cnt);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_ok);
      count_reg  <= count_reg + CW'(push_cnt) - CW'(pop_ok);
    end
  end

  assign head_inst = inst_mem[rd_ptr_reg];
  assign head_pc   = pc_mem[rd_ptr_reg];
  assign empty     = (count_reg == '0);
  assign count     = count_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: batch fetch from icache into an instruction queue.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int LINE_NUM       = 2,
  parameter int WORDS_PER_LINE = 16,
  parameter int WORD_WIDTH     = 32,
  parameter int FETCH_WIDTH    = 4,
  parameter int IQ_DEPTH       = 8,
  parameter int RESET_ADDR     = 0,
  localparam int TOTAL         = LINE_NUM * WORDS_PER_LINE,
  localparam int ADDR_W        = $clog2(TOTAL)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  output logic [ADDR_W-1:0]                     fetch_addr,
  input  logic [FETCH_WIDTH-1:0][WORD_WIDTH-1:0] inst_batch,
  input  logic                                  redirect_valid,
  input  logic [ADDR_W-1:0]                     redirect_addr,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WORD_WIDTH-1:0]                 out_inst,
  output logic [ADDR_W-1:0]                     out_pc,
  output logic [31:0]                           stall_cycles,
  output logic [31:0]                           fetch_count
);

  localparam int CW  = $clog2(IQ_DEPTH + 1);
  localparam int NW  = $clog2(FETCH_WIDTH + 1);
  localparam int PW1 = ADDR_W + 1;
  localparam logic [PW1-1:0] TOTAL_P = PW1'(TOTAL);
  localparam logic [PW1-1:0] FW_P    = PW1'(FETCH_WIDTH);

  fetch_state_e       state_reg, state_next;
  logic [PW1-1:0]     ptr_reg, ptr_next;
  logic [ADDR_W-1:0]  fetch_addr_reg, fetch_addr_next;
  logic [PW1-1:0]     remaining;
  logic [PW1-1:0]     batch_n;
  logic [CW-1:0]      iq_count;
  logic [CW-1:0]      free_slots;
  logic               enq_ok;
  logic               iq_empty;
  logic               iq_flush;
  logic               iq_pop;
  logic [NW-1:0]      push_cnt;
  logic [WORD_WIDTH-1:0] head_inst;
  logic [ADDR_W-1:0]  head_pc;

  // Free space is judged on the pre-edge count, so a same-edge pop never helps.
  assign free_slots = CW'(IQ_DEPTH) - iq_count;
  assign enq_ok     = (free_slots >= CW'(FETCH_WIDTH));
  assign remaining  = TOTAL_P - ptr_reg;
  assign batch_n    = (remaining < FW_P) ? remaining : FW_P;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= RUN;
      ptr_reg        <= PW1'(RESET_ADDR);
      fetch_addr_reg <= ADDR_W'(RESET_ADDR);
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      fetch_addr_reg <= fetch_addr_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    fetch_addr_next = fetch_addr_reg;
    push_cnt        = '0;
    iq_flush        = 1'b0;
    if (redirect_valid) begin
      iq_flush        = 1'b1;
      state_next      = RUN;
      ptr_next        = {1'b0, redirect_addr};
      fetch_addr_next = redirect_addr;
    end else begin
      case (state_reg)
        RUN: begin
          if (ptr_reg >= TOTAL_P) begin
            state_next = END;
          end else if (enq_ok) begin
            push_cnt = NW'(batch_n);
            ptr_next = ptr_reg + batch_n;
            // Once the end is reached, fetch_addr keeps the last batch address.
            if (ptr_next >= TOTAL_P) state_next = END;
            else fetch_addr_next = ptr_next[ADDR_W-1:0];
          end else begin
            state_next = STALL;
          end
        end
        STALL: begin
          if (enq_ok) state_next = RUN;
        end
        END: begin
          state_next = END;
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign iq_pop = out_ready && !iq_empty && !redirect_valid;

  fetch_iq #(
    .DEPTH (IQ_DEPTH),
    .FW    (FETCH_WIDTH),
    .WW    (WORD_WIDTH),
    .AW    (ADDR_W)
  ) u_iq (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (iq_flush),
    .push_cnt  (push_cnt),
    .push_inst (inst_batch),
    .push_pc   (ptr_reg[ADDR_W-1:0]),
    .pop       (iq_pop),
    .head_inst (head_inst),
    .head_pc   (head_pc),
    .empty     (iq_empty),
    .count     (iq_count)
  );

  assign fetch_addr = fetch_addr_reg;
  assign out_valid  = !iq_empty;
  assign out_inst   = iq_empty ? '0 : head_inst;
  assign out_pc     = iq_empty ? '0 : head_pc;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] fetch_count_reg;
  logic [32:0] fetch_sum;

  assign fetch_sum = {1'b0, fetch_count_reg} + 33'(push_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= '0;
      fetch_count_reg  <= '0;
    end else begin
      if (state_reg == STALL && !redirect_valid && stall_cycles_reg != '1)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (push_cnt != '0)
        fetch_count_reg <= fetch_sum[32] ? '1 : fetch_sum[31:0];
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign fetch_count  = fetch_count_reg;
`else
  assign stall_cycles = '0;
  assign fetch_count  = '0;
`endif

endmodule
